// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data SRAM responder: FSM encodings and store byte-enable codes.
package data_sram_resp_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [3:0] WEN_RD  = 4'b0000;
  localparam logic [3:0] WEN_B0  = 4'b0001;
  localparam logic [3:0] WEN_B1  = 4'b0010;
  localparam logic [3:0] WEN_B2  = 4'b0100;
  localparam logic [3:0] WEN_B3  = 4'b1000;
  localparam logic [3:0] WEN_HLO = 4'b0011;
  localparam logic [3:0] WEN_HHI = 4'b1100;
  localparam logic [3:0] WEN_W   = 4'b1111;

  // Accepts only the encodings a load/store unit can emit, with halves and words aligned.
  function automatic logic wen_legal(input logic [3:0] wen, input logic [1:0] off);
    logic ok;
    case (wen)
      WEN_RD, WEN_B0, WEN_B1, WEN_B2, WEN_B3: ok = 1'b1;
      WEN_HLO: ok = ~off[1];
      WEN_HHI: ok = off[1];
      WEN_W:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_sram_resp_sram_bank.sv
// Byte-writable word array with a registered read port.
module sram_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [1 << AW];

  // Byte-lane writes; the array itself is never cleared.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register holds its value except on a read access.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: inserts WAIT_CYC wait states per access, validates byte enables,
// and reports completion/rejection with single-cycle pulses.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int AW       = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        stallreq,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
  localparam logic       HAS_WAIT = (WAIT_CYC != 0);

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    wen_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;

  logic          go;
  logic [3:0]    acc_wen;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic [31:0]   acc_wdata;
  logic          acc_ok;
  logic [3:0]    bank_we;
  logic          bank_re;

  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  // Select live or latched request, decide whether it completes this edge, drive the bank.
  always_comb begin
    go        = 1'b0;
    acc_wen   = wen_q;
    acc_idx   = idx_q;
    acc_off   = off_q;
    acc_wdata = wdata_q;
    if (!HAS_WAIT) begin
      go        = (state == IDLE) && en;
      acc_wen   = wen;
      acc_idx   = addr[AW+1:2];
      acc_off   = addr[1:0];
      acc_wdata = wdata;
    end else begin
      go = (state == WAIT) && (cnt == 4'd0);
    end
    acc_ok   = wen_legal(acc_wen, acc_off);
    bank_we  = (go && acc_ok && !rst) ? acc_wen : 4'b0000;
    bank_re  = go && acc_ok && !rst && (acc_wen == WEN_RD);
    stallreq = ((state == IDLE) && en && HAS_WAIT) || ((state == WAIT) && (cnt != 4'd0));
  end

  // Wait-state FSM and completion/rejection pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      resp_valid <= go;
      err        <= go && !acc_ok;
      if (state == IDLE) begin
        if (en && HAS_WAIT) begin
          state <= WAIT;
          cnt   <= CNT_INIT;
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Capture the request when it is accepted so WAIT cycles can ignore the ports.
  always_ff @(posedge clk) begin
    if (state == IDLE && en) begin
      wen_q   <= wen;
      idx_q   <= addr[AW+1:2];
      off_q   <= addr[1:0];
      wdata_q <= wdata;
    end
  end

  sram_bank #(.AW(AW)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .re    (bank_re),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Transaction-level bench for data_sram_resp with WAIT_CYC = 0, 2 and 3 instances.
module tb_data_sram_resp;

  localparam int AW    = 10;
  localparam int NI    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    int          rst_at;
  } req_t;

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic        en         [NI];
  logic [3:0]  wen        [NI];
  logic [31:0] addr       [NI];
  logic [31:0] wdata      [NI];
  logic [31:0] rdata      [NI];
  logic        resp_valid [NI];
  logic        stallreq   [NI];
  logic        err        [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_sram_resp #(.AW(AW), .WAIT_CYC(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .en         (en[g]),
      .wen        (wen[g]),
      .addr       (addr[g]),
      .wdata      (wdata[g]),
      .rdata      (rdata[g]),
      .resp_valid (resp_valid[g]),
      .stallreq   (stallreq[g]),
      .err        (err[g])
    );
  end

  int          nchk = 0;
  int          nerr = 0;
  bit [31:0]   mm       [NI][DEPTH];
  bit          known    [NI][DEPTH];
  logic [31:0] m_rdata  [NI];
  bit          rd_known [NI];
  bit          exp_rv   [NI];
  bit          exp_err  [NI];
  req_t        q        [NI][$];
  req_t        cur      [NI];
  bit          cur_v    [NI];
  bit          active   [NI];
  int          pres     [NI];
  int          gap_left [NI];
  int          stall_seen [NI];
  int          err_seen   [NI];
  bit          grst;
  logic [3:0]  wen_list [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  function automatic int wc_of(int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic int unsigned tab(int k);
    return (k * 61) % DEPTH;
  endfunction

  function automatic bit legal(logic [3:0] w, logic [1:0] off);
    case (w)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8: return 1'b1;
      4'h3: return off < 2;
      4'hC: return off >= 2;
      4'hF: return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push(int g, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                               int gap = 0, int rst_at = -1);
    req_t r;
    r.wen = w; r.addr = a; r.wdata = d; r.gap = gap; r.rst_at = rst_at;
    q[g].push_back(r);
  endfunction

  function automatic bit all_idle();
    for (int g = 0; g < NI; g++) if (cur_v[g] || q[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // What a completed access must produce, from the memory image.
  function automatic void model_access(int g, req_t r);
    int unsigned ix = (r.addr >> 2) % DEPTH;
    bit ok = legal(r.wen, r.addr[1:0]);
    exp_rv[g]  = 1'b1;
    exp_err[g] = !ok;
    if (ok) begin
      if (r.wen == 4'h0) begin
        m_rdata[g]  = mm[g][ix];
        rd_known[g] = known[g][ix];
      end else begin
        for (int b = 0; b < 4; b++)
          if (r.wen[b]) mm[g][ix][8*b +: 8] = r.wdata[8*b +: 8];
        if (r.wen == 4'hF) known[g][ix] = 1'b1;
      end
    end
  endfunction

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, g, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("resp_valid", g, 32'(resp_valid[g]), 32'(exp_rv[g]));
      chk("err", g, 32'(err[g]), 32'(exp_err[g]));
      if (rd_known[g]) chk("rdata", g, rdata[g], m_rdata[g]);
      if (err[g] === 1'b1) err_seen[g]++;
    end
    for (int g = 0; g < NI; g++) begin
      active[g] = 1'b0;
      en[g]     = 1'b0;
      wen[g]    = 4'($urandom);
      addr[g]   = $urandom;
      wdata[g]  = $urandom;
      if (!cur_v[g] && q[g].size() != 0) begin
        cur[g]      = q[g].pop_front();
        cur_v[g]    = 1'b1;
        pres[g]     = 0;
        gap_left[g] = cur[g].gap;
      end
      if (cur_v[g]) begin
        if (gap_left[g] > 0) gap_left[g]--;
        else begin
          active[g] = 1'b1;
          en[g]     = 1'b1;
          // after acceptance the port carries garbage; only the first cycle is meaningful
          if (pres[g] == 0) begin
            wen[g]   = cur[g].wen;
            addr[g]  = cur[g].addr;
            wdata[g] = cur[g].wdata;
          end
        end
      end
      rst[g] = grst || (active[g] && pres[g] == cur[g].rst_at);
    end
    #1;
    for (int g = 0; g < NI; g++) begin
      if (rst[g]) begin
        if (active[g]) cur_v[g] = 1'b0;
        exp_rv[g]   = 1'b0;
        exp_err[g]  = 1'b0;
        m_rdata[g]  = '0;
        rd_known[g] = 1'b1;
      end else begin
        if (stallreq[g] === 1'b1) stall_seen[g]++;
        chk("stallreq", g, 32'(stallreq[g]), 32'(active[g] && pres[g] < wc_of(g)));
        if (active[g] && pres[g] >= wc_of(g)) begin
          model_access(g, cur[g]);
          cur_v[g] = 1'b0;
        end else begin
          exp_rv[g]  = 1'b0;
          exp_err[g] = 1'b0;
          if (active[g]) pres[g]++;
        end
      end
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk("drain_idle", -1, 32'(all_idle()), 32'd1);
    if (!all_idle()) for (int g = 0; g < NI; g++) begin
      q[g].delete();
      cur_v[g] = 1'b0;
    end
    step();
  endtask

  initial begin
    grst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1; en[g] = 1'b0; wen[g] = '0; addr[g] = '0; wdata[g] = '0;
      m_rdata[g] = '0; rd_known[g] = 1'b1; exp_rv[g] = 1'b0; exp_err[g] = 1'b0;
      cur_v[g] = 1'b0; stall_seen[g] = 0; err_seen[g] = 0;
    end
    step();
    step();
    grst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      chk("reset_rdata", g, rdata[g], 32'h0);
      chk("reset_stall", g, 32'(stallreq[g]), 32'd0);
    end

    // full-word preload of the working set, with random upper address bits
    for (int g = 0; g < NI; g++)
      for (int k = 0; k < 16; k++)
        push(g, 4'hF, ($urandom & 32'hFFFF_F000) | (tab(k) << 2), $urandom);
    push(1, 4'hF, 32'h20, 32'h1122_3344);
    push(2, 4'hF, 32'h40, 32'h55AA_55AA);
    drain(400);

    for (int g = 0; g < NI; g++) begin stall_seen[g] = 0; err_seen[g] = 0; end
    push(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    push(0, 4'h0, 32'h10, 32'h0);
    push(1, 4'h0, 32'hF4, 32'h0);
    drain(100);
    chk("wc0_write_read", 0, rdata[0], 32'hDEAD_BEEF);
    chk("wc0_no_stall", 0, 32'(stall_seen[0]), 32'd0);
    chk("wc2_stall_cycles", 1, 32'(stall_seen[1]), 32'd2);

    for (int g = 0; g < NI; g++) begin stall_seen[g] = 0; err_seen[g] = 0; end
    push(0, 4'hF, 32'h13, 32'h0BAD_F00D);
    push(0, 4'h0, 32'h10, 32'h0);
    push(0, 4'hF, 32'h1000, 32'hCAFE_F00D);
    push(0, 4'h0, 32'h0, 32'h0);
    push(1, 4'h4, 32'h22, 32'h00AA_0000);
    push(1, 4'h0, 32'h20, 32'h0);
    push(2, 4'hF, 32'h40, 32'h1234_5678, 0, 2);
    push(2, 4'h0, 32'h40, 32'h0, 1);
    drain(100);
    chk("misaligned_err_count", 0, 32'(err_seen[0]), 32'd1);
    chk("wrap_read", 0, rdata[0], 32'hCAFE_F00D);
    chk("byte_merge", 1, rdata[1], 32'h11AA_3344);
    chk("rst_drops_write", 2, rdata[2], 32'h55AA_55AA);
    chk("rst_stall_cycles", 2, 32'(stall_seen[2]), 32'd5);
    push(0, 4'h0, 32'h10, 32'h0);
    drain(20);
    chk("err_word_unchanged", 0, rdata[0], 32'hDEAD_BEEF);

    for (int g = 0; g < NI; g++)
      for (int n = 0; n < 150; n++) begin
        logic [3:0] w;
        w = ($urandom_range(0, 3) == 0) ? 4'h0 :
            (($urandom_range(0, 9) < 8) ? wen_list[$urandom_range(0, 7)] : 4'($urandom));
        push(g, w,
             ($urandom & 32'hFFFF_F000) | (tab($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
             $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
